// File: rtl/ascon_demo.sv
// ascon_demo -- iterative ASCON-128 AEAD demonstrator, one permutation round per clock.
//
// The core runs an encryption pass of 54 rounds: p12 init, four p6 for the
// associated data, one p6 for message block 1, and the p12 finalisation.
// With ASCON_DECRYPT_EN defined, a second 54-round pass then decrypts the
// ciphertext the core has just produced and checks the tag.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   start              begin a run; sampled only while idle and not during done
//   x0..x4             IV, key K0/K1, nonce N0/N1
//   d0..d2             associated-data blocks A1..A3
//   plin0, plin1       plaintext blocks P1, P2
//   busy, done         run in progress / one-cycle completion pulse
//   y0..y4             encryption-pass state after the final p12
//   c0, c1, tag        ciphertext blocks and 128-bit tag
//   dec0, dec1, tag_ok decryption results (tied to 0 without ASCON_DECRYPT_EN)
//
// Configuration macro: ASCON_DECRYPT_EN

module ascon_demo (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  x0,
  input  logic [63:0]  x1,
  input  logic [63:0]  x2,
  input  logic [63:0]  x3,
  input  logic [63:0]  x4,
  input  logic [63:0]  d0,
  input  logic [63:0]  d1,
  input  logic [63:0]  d2,
  input  logic [63:0]  plin0,
  input  logic [63:0]  plin1,
  output logic         busy,
  output logic         done,
  output logic [63:0]  y0,
  output logic [63:0]  y1,
  output logic [63:0]  y2,
  output logic [63:0]  y3,
  output logic [63:0]  y4,
  output logic [63:0]  c0,
  output logic [63:0]  c1,
  output logic [127:0] tag,
  output logic [63:0]  dec0,
  output logic [63:0]  dec1,
  output logic         tag_ok
);

  localparam logic [63:0] PAD  = 64'h8000_0000_0000_0000;
  localparam logic [5:0]  LAST = 6'd54;   // rc value of the capture cycle after round 53

  typedef logic [4:0][63:0] perm_t;

`ifdef ASCON_DECRYPT_EN
  typedef enum logic [1:0] {IDLE, ENC, DEC} fsm_t;
`else
  typedef enum logic [1:0] {IDLE, ENC} fsm_t;
`endif

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One full round: constant addition, bitsliced S-box, linear diffusion.
  function automatic perm_t round_fn(input perm_t si, input logic [3:0] i);
    perm_t x;
    perm_t t;
    perm_t o;
    x    = si;
    x[2] = x[2] ^ {56'd0, ~i, i};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    t[0] = ~x[0] & x[1];
    t[1] = ~x[1] & x[2];
    t[2] = ~x[2] & x[3];
    t[3] = ~x[3] & x[4];
    t[4] = ~x[4] & x[0];
    x[0] = x[0] ^ t[1];
    x[1] = x[1] ^ t[2];
    x[2] = x[2] ^ t[3];
    x[3] = x[3] ^ t[4];
    x[4] = x[4] ^ t[0];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    o[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
    o[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
    o[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
    o[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
    o[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    return o;
  endfunction

  fsm_t        state, state_nx;
  logic        start_run, run, cap_enc;
  logic        in_dec;
  logic [5:0]  rc;
  logic [3:0]  ci, ci_nx;
  logic [63:0] k0_r, k1_r, a1_r, a2_r, a3_r, p1_r, p2_r;
  logic [63:0] blk0, blk1;
  logic [63:0] m0, m1;
  perm_t       s, s_pre, s_nx;

`ifdef ASCON_DECRYPT_EN
  logic        cap_dec;
  logic [63:0] iv_r, n0_r, n1_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    run       = 1'b0;
    cap_enc   = 1'b0;
`ifdef ASCON_DECRYPT_EN
    cap_dec   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // done is high only in the cycle right after a run ends, so start is ignored there
        if (start && !done) begin
          start_run = 1'b1;
          state_nx  = ENC;
        end
      end
      ENC: begin
        if (rc == LAST) begin
          cap_enc  = 1'b1;
`ifdef ASCON_DECRYPT_EN
          state_nx = DEC;
`else
          state_nx = IDLE;
`endif
        end else begin
          run = 1'b1;
        end
      end
`ifdef ASCON_DECRYPT_EN
      DEC: begin
        if (rc == LAST) begin
          cap_dec  = 1'b1;
          state_nx = IDLE;
        end else begin
          run = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

`ifdef ASCON_DECRYPT_EN
  assign in_dec = (state == DEC);
`else
  assign in_dec = 1'b0;
`endif

  // Message-side operand: plaintext when encrypting, captured ciphertext when decrypting.
  assign blk0 = in_dec ? c0 : p1_r;
  assign blk1 = in_dec ? c1 : p2_r;

  // Block XORs between permutations are folded into the first round that follows them;
  // rc 42 also absorbs the last-block pad and the finalisation key XOR.
  always_comb begin
    s_pre = s;
    case (rc)
      6'd12: begin
        s_pre[3] = s[3] ^ k0_r;
        s_pre[4] = s[4] ^ k1_r;
        s_pre[0] = s[0] ^ a1_r;
      end
      6'd18: s_pre[0] = s[0] ^ a2_r;
      6'd24: s_pre[0] = s[0] ^ a3_r;
      6'd30: s_pre[0] = s[0] ^ PAD;
      6'd36: begin
        s_pre[4] = s[4] ^ 64'd1;
        s_pre[0] = in_dec ? blk0 : (s[0] ^ blk0);
      end
      6'd42: begin
        s_pre[0] = (in_dec ? blk1 : (s[0] ^ blk1)) ^ PAD;
        s_pre[1] = s[1] ^ k0_r;
        s_pre[2] = s[2] ^ k1_r;
      end
      default: ;
    endcase
  end

  assign s_nx = round_fn(s_pre, ci);

  // Constant index restarts at 6 for every p6 and at 0 for the final p12 (after rc 41).
  assign ci_nx = (ci == 4'd11) ? ((rc == 6'd41) ? 4'd0 : 4'd6) : ci + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      y0   <= '0;
      y1   <= '0;
      y2   <= '0;
      y3   <= '0;
      y4   <= '0;
      c0   <= '0;
      c1   <= '0;
      tag  <= '0;
      rc   <= '0;
      ci   <= '0;
      s    <= '0;
      m0   <= '0;
      m1   <= '0;
      k0_r <= '0;
      k1_r <= '0;
      a1_r <= '0;
      a2_r <= '0;
      a3_r <= '0;
      p1_r <= '0;
      p2_r <= '0;
`ifdef ASCON_DECRYPT_EN
      iv_r   <= '0;
      n0_r   <= '0;
      n1_r   <= '0;
      dec0   <= '0;
      dec1   <= '0;
      tag_ok <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start_run) begin
        k0_r <= x1;
        k1_r <= x2;
        a1_r <= d0;
        a2_r <= d1;
        a3_r <= d2;
        p1_r <= plin0;
        p2_r <= plin1;
`ifdef ASCON_DECRYPT_EN
        iv_r <= x0;
        n0_r <= x3;
        n1_r <= x4;
`endif
        s    <= {x4, x3, x2, x1, x0};
        rc   <= '0;
        ci   <= '0;
        busy <= 1'b1;
      end
      if (run) begin
        s  <= s_nx;
        rc <= rc + 6'd1;
        ci <= ci_nx;
        if (rc == 6'd36) m0 <= s[0] ^ blk0;
        if (rc == 6'd42) m1 <= s[0] ^ blk1;
      end
      if (cap_enc) begin
        y0  <= s[0];
        y1  <= s[1];
        y2  <= s[2];
        y3  <= s[3];
        y4  <= s[4];
        c0  <= m0;
        c1  <= m1;
        tag <= {s[3] ^ k0_r, s[4] ^ k1_r};
`ifdef ASCON_DECRYPT_EN
        s   <= {n1_r, n0_r, k1_r, k0_r, iv_r};
        rc  <= '0;
        ci  <= '0;
`else
        done <= 1'b1;
        busy <= 1'b0;
`endif
      end
`ifdef ASCON_DECRYPT_EN
      if (cap_dec) begin
        dec0   <= m0;
        dec1   <= m1;
        tag_ok <= ({s[3] ^ k0_r, s[4] ^ k1_r} == tag);
        done   <= 1'b1;
        busy   <= 1'b0;
      end
`endif
    end
  end

`ifndef ASCON_DECRYPT_EN
  assign dec0   = '0;
  assign dec1   = '0;
  assign tag_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_demo.sv
// tb_ascon_demo -- scoreboard bench for ascon_demo.
// A reference ASCON pass model predicts every run when it is started; the
// prediction is popped and compared when done pulses.

module tb_ascon_demo;

  typedef logic [4:0][63:0]  perm_t;
  typedef logic [11:0][63:0] res_t;   // y0..y4, c0, c1, tag_hi, tag_lo, dec0, dec1, tag_ok
  typedef struct packed {
    logic [63:0] iv, k0, k1, n0, n1, a1, a2, a3, p1, p2;
  } vec_t;

`ifdef ASCON_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
  localparam int LAT    = 110;
`else
  localparam bit DEC_EN = 1'b0;
  localparam int LAT    = 55;
`endif

  localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;
  localparam vec_t NOM = '{64'h80400C0600000000, 64'h265F1C12888E151A, 64'hC74F26B30A8C44B2,
                           64'h369C801F3AE8D0EA, 64'h9BF367D58FD211FF, 64'd7895160, 64'd8882055,
                           64'd37008, 64'h1234567890ABCDEF, 64'h1234567890ABCDEF};

  logic         clk, rst_n, start;
  logic [63:0]  x0, x1, x2, x3, x4, d0, d1, d2, plin0, plin1;
  logic         busy, done, tag_ok;
  logic [63:0]  y0, y1, y2, y3, y4, c0, c1, dec0, dec1;
  logic [127:0] tag;

  int    n_cmp = 0;
  int    n_bad = 0;
  res_t  sb[$];
  string names[12] = '{"y0", "y1", "y2", "y3", "y4", "c0", "c1", "tag_hi", "tag_lo",
                       "dec0", "dec1", "tag_ok"};

  ascon_demo dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .d0(d0), .d1(d1), .d2(d2), .plin0(plin0), .plin1(plin1),
    .busy(busy), .done(done),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .c0(c0), .c1(c1), .tag(tag), .dec0(dec0), .dec1(dec1), .tag_ok(tag_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic perm_t perm(input perm_t st, input int nr);
    logic [63:0] x[5];
    logic [63:0] t[5];
    perm_t o;
    for (int k = 0; k < 5; k++) x[k] = st[k];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] ^= 64'((15 - r) * 16 + r);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
      x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
      x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
      x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
    end
    for (int k = 0; k < 5; k++) o[k] = x[k];
    return o;
  endfunction

  // Straight-line reference: encrypt, then decrypt the produced ciphertext.
  function automatic res_t model(input vec_t v);
    res_t        r;
    perm_t       s;
    logic [63:0] ad[4];
    logic [63:0] b1, b2, q1, q2;
    r  = '0;
    ad = '{v.a1, v.a2, v.a3, PAD};
    for (int pass = 0; pass < 2; pass++) begin
      s[0] = v.iv; s[1] = v.k0; s[2] = v.k1; s[3] = v.n0; s[4] = v.n1;
      s = perm(s, 12);
      s[3] ^= v.k0; s[4] ^= v.k1;
      for (int j = 0; j < 4; j++) begin
        s[0] ^= ad[j];
        s = perm(s, 6);
      end
      s[4] ^= 64'd1;
      b1 = (pass == 0) ? v.p1 : r[5];
      q1 = s[0] ^ b1;
      s[0] = (pass == 0) ? q1 : b1;
      s = perm(s, 6);
      b2 = (pass == 0) ? v.p2 : r[6];
      q2 = s[0] ^ b2;
      s[0] = ((pass == 0) ? q2 : b2) ^ PAD;
      s[1] ^= v.k0; s[2] ^= v.k1;
      s = perm(s, 12);
      if (pass == 0) begin
        for (int k = 0; k < 5; k++) r[k] = s[k];
        r[5] = q1; r[6] = q2;
        r[7] = s[3] ^ v.k0; r[8] = s[4] ^ v.k1;
      end else if (DEC_EN) begin
        r[9] = q1; r[10] = q2;
        r[11] = {63'd0, ((s[3] ^ v.k0) == r[7]) && ((s[4] ^ v.k1) == r[8])};
      end
    end
    return r;
  endfunction

  function automatic res_t snap();
    res_t r;
    r[0] = y0; r[1] = y1; r[2] = y2; r[3] = y3; r[4] = y4;
    r[5] = c0; r[6] = c1; r[7] = tag[127:64]; r[8] = tag[63:0];
    r[9] = dec0; r[10] = dec1; r[11] = {63'd0, tag_ok};
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < 20; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    x0 = v.iv; x1 = v.k0; x2 = v.k1; x3 = v.n0; x4 = v.n1;
    d0 = v.a1; d1 = v.a2; d2 = v.a3; plin0 = v.p1; plin1 = v.p2;
  endtask

  // Called at posedge+1; returns at E0+1 with start released.
  task automatic start_run(input vec_t v, input bit push);
    drive_vec(v);
    start = 1'b1;
    if (push) sb.push_back(model(v));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc counts edges, bc counts busy-high samples before done.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = (busy === 1'b1) ? 1 : 0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bc++;
    end
  endtask

  task automatic test_reset();
    res_t got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = snap();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== 64'd0) begin
        n_bad++; $display("FAIL reset.%s got %h want 0", names[k], got[k]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset.done got %b want 0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    res_t got, exp;
    int   cyc, bc;
    start_run(NOM, 1'b1);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT) begin n_bad++; $display("FAIL nominal.latency got %0d want %0d", cyc, LAT); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL nominal.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_latency();
    res_t got, exp;
    int   cyc, bc;
    @(posedge clk); #1;
    start_run(NOM, 1'b1);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT) begin n_bad++; $display("FAIL latency.done got %0d want %0d", cyc, LAT); end
    n_cmp++;
    if (bc !== LAT) begin n_bad++; $display("FAIL latency.busy_cycles got %0d want %0d", bc, LAT); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL latency.busy_at_done got %b want 0", busy); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL latency.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL latency.done_width got %b want 0", done); end
    n_cmp++;
    if (snap() !== got) begin n_bad++; $display("FAIL latency.hold got %h want %h", snap(), got); end
  endtask

  task automatic test_input_independence();
    res_t got, exp;
    int   cyc, bc;
    start_run(NOM, 1'b1);
    drive_vec(rand_vec());
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT) begin n_bad++; $display("FAIL indep.latency got %0d want %0d", cyc, LAT); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL indep.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_abort();
    res_t got, exp;
    int   cyc, bc;
    bit   seen;
    @(posedge clk); #1;
    start_run(NOM, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    got = snap();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== 64'd0) begin
        n_bad++; $display("FAIL abort.%s got %h want 0", names[k], got[k]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort.busy got %b want 0", busy); end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (130) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort.no_done got %b want 0", seen); end
    start_run(NOM, 1'b1);
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT) begin n_bad++; $display("FAIL abort.restart_latency got %0d want %0d", cyc, LAT); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL abort.restart.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp, exp1;
    vec_t v3;
    int   cyc, bc;
    v3    = NOM;
    v3.p1 = '0;
    exp1  = model(NOM);
    @(posedge clk); #1;
    start_run(NOM, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    // start pulse mid-run with different inputs must not disturb the run
    drive_vec(rand_vec());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT - 21) begin n_bad++; $display("FAIL b2b.first_latency got %0d want %0d", cyc, LAT - 21); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL b2b.first.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
    // start held from the done cycle: ignored there, accepted the cycle after
    drive_vec(v3);
    start = 1'b1;
    sb.push_back(model(v3));
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b.start_with_done got busy %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b.restart got busy %b want 1", busy); end
    wait_done(cyc, bc);
    n_cmp++;
    if (cyc !== LAT) begin n_bad++; $display("FAIL b2b.second_latency got %0d want %0d", cyc, LAT); end
    got = snap();
    exp = sb.pop_front();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL b2b.second.%s got %h want %h", names[k], got[k], exp[k]);
      end
    end
    n_cmp++;
    if (got[5] !== (exp1[5] ^ NOM.p1)) begin
      n_bad++; $display("FAIL b2b.keystream got %h want %h", got[5], exp1[5] ^ NOM.p1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive_vec('0);
    test_reset();
    test_nominal();
    test_latency();
    test_input_independence();
    test_abort();
    test_back_to_back();
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard.leftover got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ascon_demo.md
# ascon_demo

Iterative ASCON-128 AEAD demonstrator, module name `ascon_demo`. It takes an IV, a 128-bit key, a 128-bit nonce, three 64-bit associated-data blocks and two 64-bit plaintext blocks. It encrypts them and exposes the final 320-bit permutation state. It then runs a decryption pass on its own ciphertext to recover the plaintext and check the tag. One permutation round executes per clock; the block is a self-contained showcase core with a start/done handshake.

## Interface
No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, active-low, synchronous.
- `start`  in  1  begin operation; sampled only when idle.
- `x0`  in  64  IV (ASCON-128: 0x80400C0600000000).
- `x1`, `x2`  in  64 each  key words K0 and K1 (K0 is the high word).
- `x3`, `x4`  in  64 each  nonce words N0 and N1.
- `d0`, `d1`, `d2`  in  64 each  associated-data blocks A1, A2 and A3.
- `plin0`, `plin1`  in  64 each  plaintext blocks P1 and P2.
- `busy`  out  1  high from the start edge until done.
- `done`  out  1  one-cycle pulse when all outputs are valid.
- `y0`–`y4`  out  64 each  encryption-pass state S0–S4 after finalization p12.
- `c0`, `c1`  out  64 each  ciphertext blocks C1 and C2.
- `tag`  out  128  {S3^K0, S4^K1} from the encryption pass.
- `dec0`, `dec1`  out  64 each  decrypted blocks.
- `tag_ok`  out  1  decryption tag equals `tag`.

## Operation
- On `start` while idle, all inputs are registered. Inputs are don't-care afterwards.
- Permutation round r, with constant index i:
  - Constant addition: S2 ^= c_i. The constants are f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
  - p12 uses i = 0..11. p6 uses i = 6..11.
  - S-box, bitsliced:
    - x0^=x4; x4^=x3; x2^=x1.
    - t_k = ~x_k & x_(k+1 mod 5).
    - x_k ^= t_(k+1).
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer, right-rotates: S0 (19,28), S1 (61,39), S2 (1,6), S3 (10,17), S4 (7,41). Each word becomes Si ^ rotr(Si,a) ^ rotr(Si,b).
- Pass sequence (all arithmetic is XOR on 64-bit words):
  1. Init: S = IV, K0, K1, N0, N1; apply p12; then S3^=K0, S4^=K1.
  2. AD: for A1, A2, A3, and the pad block 0x8000000000000000, do S0^=A then p6 (four p6 in total). Then S4^=1.
  3. Message block 1: encrypt C1=S0^P1, S0=C1. Decrypt P1=S0^C1, S0=C1. Then p6.
  4. Message block 2: C2=S0^P2, S0=C2 (decrypt mirrors step 3). No permutation follows.
  5. Pad: S0^=0x8000000000000000.
  6. Final: S1^=K0, S2^=K1; apply p12. Tag = {S3^K0, S4^K1}.
- Each pass takes 54 rounds.
- Block XORs are fused combinationally into the first round of the permutation that follows them.
  - The step-4/5 XORs are fused into the first p12 round.
- The encryption pass captures `y*`, `c*` and `tag`.
- The decryption pass uses the captured `c0`/`c1` and produces `dec0`, `dec1` and `tag_ok`.
- FSM states: IDLE → ENC → DEC → IDLE.
  - A 6-bit round counter and a phase field select the constant and the fused XOR.
- `start` while busy is ignored.

## Timing
- Reset (synchronous, `rst_n`=0 at a rising edge):
  - All outputs go to 0; FSM goes to IDLE.
  - Reset during operation aborts the run. No `done` is produced.
- Start edge E0 loads the state and raises `busy`.
- Edges E1–E54 perform the encryption rounds.
- E55 captures the encryption outputs and reloads the state for decryption.
- Edges E56–E109 perform the decryption rounds.
- E110 captures `dec*`/`tag_ok`, pulses `done` for one cycle and drops `busy`.
- Latency from the start edge to `done` is 110 cycles with decryption, 55 without.
- Outputs hold their values until the next completed run or reset.
- `start` in the same cycle as `done` is ignored. A new run starts no earlier than the cycle after `done`.

## Configuration
- `ASCON_DECRYPT_EN` defined:
  - The DEC phase is included and latency is 110.
- Not defined:
  - No DEC state exists; `done` fires at E55.
  - `dec0`, `dec1` and `tag_ok` are tied to 0.

## Test plan
- Reset check: `rst_n`=0 for 2 cycles → all outputs 0, `busy`=0, `done`=0.
- Nominal vector:
  - Stimulus: IV 80400C0600000000, K 265F1C12888E151A/C74F26B30A8C44B2, N 369C801F3AE8D0EA/9BF367D58FD211FF, AD 7895160/8882055/37008 (decimal), P 1234567890ABCDEF twice.
  - Required: `y*`, `c*` and `tag` match the golden ASCON-128 model; `dec0`=`dec1`=1234567890ABCDEF; `tag_ok`=1.
- Latency check: `done` rises exactly 110 cycles after the start edge (55 with `ASCON_DECRYPT_EN` undefined); `busy` is high for exactly that window.
- Input independence: change every input at E1 → results are identical to the nominal vector.
- Abort: drop `rst_n` at E30 → outputs 0 and no `done`. A restart then produces the nominal results.
- Back-to-back runs: pulse `start` during `busy` → ignored. Restart the cycle after `done` with P1=0 → `dec0`=0, `tag_ok`=1, and `c0` equals the first-run keystream.
